timer_alarm_scheduler: RTL and testbench

Shares one hardware compare channel (TIMECMP/tint of the AHB3-Lite timer, timer0) among REQUESTERS independent alarm clients. Each client arms an absolute 64-bit deadline. The scheduler scans the armed set, programs the earliest deadline into the timer's compare register, and pulses `done` to the owning client when the timer interrupt fires. It then reschedules the next-earliest deadline. It sits beside the timer on its sideband compare-write port; no AHB traffic is involved.

---
 rtl/timer_alarm_scheduler_if.sv | 29 ++
 rtl/timer_alarm_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_timer_alarm_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_alarm_scheduler_if.sv
// Alarm client / timer sideband bundle for timer_alarm_scheduler.
// The master side is the client array plus the timer; the slave side is the scheduler.
interface timer_alarm_scheduler_if #(
  parameter int unsigned REQUESTERS = 4,
  parameter int unsigned TIME_SIZE  = 64
);

  logic [REQUESTERS-1:0]           req_valid;
  logic [REQUESTERS*TIME_SIZE-1:0] req_time;
  logic [REQUESTERS-1:0]           req_ready;
  logic [REQUESTERS-1:0]           cancel;
  logic [REQUESTERS-1:0]           armed;
  logic [REQUESTERS-1:0]           done;
  logic [TIME_SIZE-1:0]            cur_time;
  logic                            tint;
  logic                            timecmp_we;
  logic [TIME_SIZE-1:0]            timecmp_wdata;

  modport master (
    output req_valid, req_time, cancel, cur_time, tint,
    input  req_ready, armed, done, timecmp_we, timecmp_wdata
  );

  modport slave (
    input  req_valid, req_time, cancel, cur_time, tint,
    output req_ready, armed, done, timecmp_we, timecmp_wdata
  );

endinterface

// File: rtl/timer_alarm_scheduler.sv
// Multiplexes one timer compare channel among several absolute-deadline alarm clients.
// A linear scan picks the earliest armed deadline, programs it into TIMECMP, waits for
// the (time-guarded) timer interrupt and pulses done to the owner, then rescans.
// All outputs are registered; the TIMECMP strobe leaves one cycle after the decision
// so that a cancel seen in PROGRAM can still drop the write.
module timer_alarm_scheduler #(
  parameter int unsigned REQUESTERS = 4,
  parameter int unsigned TIME_SIZE  = 64
) (
  input logic                    HCLK,
  input logic                    HRESET,
  timer_alarm_scheduler_if.slave bus
);

  localparam int unsigned IDX_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REQUESTERS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SCAN    = 3'd1,
    PROGRAM = 3'd2,
    WAIT    = 3'd3,
    FIRE    = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [IDX_W-1:0]      active, active_nxt;
  logic [TIME_SIZE-1:0]  cmp, cmp_nxt;
  logic [IDX_W-1:0]      best_idx, best_idx_nxt;
  logic [TIME_SIZE-1:0]  best_time, best_time_nxt;
  logic                  best_found, best_found_nxt;
  logic [REQUESTERS-1:0] armed_q, armed_nxt;
  logic [REQUESTERS-1:0] done_q, done_nxt;
  logic [REQUESTERS-1:0] ready_q, ready_nxt;
  logic                  we_q, we_nxt;
  logic [TIME_SIZE-1:0]  wdata_q, wdata_nxt;
  logic [TIME_SIZE-1:0]  deadline [REQUESTERS];

  logic [REQUESTERS-1:0] accept;
  logic                  cand_armed;
  logic [TIME_SIZE-1:0]  cand_time;
  logic                  take;
  logic                  sel_found;
  logic [IDX_W-1:0]      sel_idx;
  logic [TIME_SIZE-1:0]  sel_time;
  logic                  fire;
  logic                  restart;
  logic                  open_state;

  assign bus.armed         = armed_q;
  assign bus.done          = done_q;
  assign bus.req_ready     = ready_q;
  assign bus.timecmp_we    = we_q;
  assign bus.timecmp_wdata = wdata_q;

  // Handshake completes only where the slot is offered and not being cancelled.
  assign accept = bus.req_valid & ready_q & ~bus.cancel;

  // Running-minimum step for the slot under the scan pointer; strict compare keeps ties at the lower index.
  always_comb begin
    cand_armed = armed_q[idx];
    cand_time  = deadline[idx];
    take       = cand_armed && (!best_found || (cand_time < best_time));
    sel_found  = best_found || cand_armed;
    sel_idx    = take ? idx : best_idx;
    sel_time   = take ? cand_time : best_time;
  end

  // Interrupt counts only once the timer has actually reached the programmed deadline.
  assign fire = bus.tint && (bus.cur_time >= cmp);

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    active_nxt     = active;
    cmp_nxt        = cmp;
    best_idx_nxt   = best_idx;
    best_time_nxt  = best_time;
    best_found_nxt = best_found;
    armed_nxt      = (armed_q | accept) & ~bus.cancel;
    done_nxt       = '0;
    we_nxt         = 1'b0;
    wdata_nxt      = wdata_q;
    restart        = 1'b0;
    open_state     = 1'b0;
    ready_nxt      = '0;

    case (state)
      IDLE: begin
        if (|accept) begin
          restart = 1'b1;
        end
      end

      SCAN: begin
        if (|bus.cancel) begin
          restart = 1'b1;
        end else if (idx == LAST_IDX) begin
          if (sel_found) begin
            state_nxt  = PROGRAM;
            active_nxt = sel_idx;
            cmp_nxt    = sel_time;
          end else begin
            // Nothing left: park the compare register out of reach.
            state_nxt = IDLE;
            we_nxt    = 1'b1;
            wdata_nxt = '1;
          end
        end else begin
          idx_nxt        = idx + 1'b1;
          best_found_nxt = sel_found;
          best_idx_nxt   = sel_idx;
          best_time_nxt  = sel_time;
        end
      end

      PROGRAM: begin
        if (|bus.cancel) begin
          restart = 1'b1;
        end else begin
          state_nxt = WAIT;
          we_nxt    = 1'b1;
          wdata_nxt = cmp;
        end
      end

      WAIT: begin
        if (bus.cancel[active]) begin
          restart = 1'b1;
        end else if (fire) begin
          state_nxt         = FIRE;
          done_nxt[active]  = 1'b1;
          armed_nxt[active] = 1'b0;
        end else if (|accept) begin
          restart = 1'b1;
        end
      end

      FIRE: begin
        restart = 1'b1;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (restart) begin
      state_nxt      = SCAN;
      idx_nxt        = '0;
      best_found_nxt = 1'b0;
    end

    open_state = (state_nxt == IDLE) || (state_nxt == WAIT);
    for (int i = 0; i < int'(REQUESTERS); i++) begin
      ready_nxt[i] = !armed_nxt[i] && open_state;
    end
  end

  // State and output registers.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state      <= IDLE;
      idx        <= '0;
      active     <= '0;
      cmp        <= '0;
      best_idx   <= '0;
      best_time  <= '0;
      best_found <= 1'b0;
      armed_q    <= '0;
      done_q     <= '0;
      ready_q    <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      active     <= active_nxt;
      cmp        <= cmp_nxt;
      best_idx   <= best_idx_nxt;
      best_time  <= best_time_nxt;
      best_found <= best_found_nxt;
      armed_q    <= armed_nxt;
      done_q     <= done_nxt;
      ready_q    <= ready_nxt;
      we_q       <= we_nxt;
      wdata_q    <= wdata_nxt;
    end
  end

  // Deadline storage, captured on acceptance.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i < int'(REQUESTERS); i++) begin
        deadline[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(REQUESTERS); i++) begin
        if (accept[i]) begin
          deadline[i] <= bus.req_time[i*TIME_SIZE +: TIME_SIZE];
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_alarm_scheduler.sv
// Bench for timer_alarm_scheduler: directed scenarios plus randomized arm sets,
// checked against a sorted-deadline reference and a simple TIMECMP/TIME timer model.
module tb_timer_alarm_scheduler;

  localparam int unsigned R  = 4;
  localparam int unsigned TW = 64;
  localparam logic [TW-1:0] PARK = '1;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;

  always #5 HCLK = ~HCLK;

  timer_alarm_scheduler_if #(.REQUESTERS(R), .TIME_SIZE(TW)) bus ();

  timer_alarm_scheduler #(.REQUESTERS(R), .TIME_SIZE(TW)) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus)
  );

  // Timer model: free-running TIME, TIMECMP written by the strobe, level interrupt.
  logic [TW-1:0] now = '0;
  logic [TW-1:0] tcmp = '1;
  logic [TW-1:0] set_val = '0;
  logic          set_req = 1'b0;
  int            cyc = 0;

  always @(posedge HCLK) begin
    now <= set_req ? set_val : now + 1;
    if (bus.timecmp_we) tcmp <= bus.timecmp_wdata;
    cyc <= cyc + 1;
  end

  assign bus.cur_time = now;
  assign bus.tint     = (now >= tcmp);

  // Event log and invariant watch.
  logic [TW-1:0] wq[$];
  int            dq_idx[$];
  logic [TW-1:0] dq_now[$];
  int            dq_cyc[$];
  int            inv_err = 0;
  logic [R-1:0]  armed_prev = '0;

  always @(negedge HCLK) begin
    if (!HRESET) begin
      if (bus.timecmp_we) wq.push_back(bus.timecmp_wdata);
      if (!$onehot0(bus.done)) inv_err++;
      if ((bus.done & ~armed_prev) != '0) inv_err++;
      for (int i = 0; i < int'(R); i++) begin
        if (bus.done[i]) begin
          dq_idx.push_back(i);
          dq_now.push_back(now);
          dq_cyc.push_back(cyc);
        end
      end
    end
    armed_prev = bus.armed;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic set_time(input logic [TW-1:0] v);
    set_val = v;
    set_req = 1'b1;
    tick(1);
    set_req = 1'b0;
  endtask

  task automatic clear_log();
    wq.delete();
    dq_idx.delete();
    dq_now.delete();
    dq_cyc.delete();
  endtask

  task automatic wait_time(input string tag, input logic [TW-1:0] t, input int budget);
    int k = 0;
    while (k < budget && bus.cur_time != t) begin
      tick(1);
      k++;
    end
    check(tag, bus.cur_time, t);
  endtask

  // Idle means nothing armed and every slot offered, which only happens in IDLE.
  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (k < budget && !(bus.armed == '0 && bus.req_ready == '1)) begin
      tick(1);
      k++;
    end
    check(tag, 64'(k < budget), 64'd1);
    tick(2);
  endtask

  function automatic logic [TW-1:0] wq_at(input int i);
    return (i < wq.size()) ? wq[i] : 64'hDEAD_0000_0000_BEEF;
  endfunction

  function automatic int dq_at(input int i);
    return (i < dq_idx.size()) ? dq_idx[i] : -1;
  endfunction

  function automatic logic [TW-1:0] dnow_at(input int i);
    return (i < dq_now.size()) ? dq_now[i] : '0;
  endfunction

  // Reference: alarms expire in (deadline, index) order; each expiry costs one compare write.
  logic [TW-1:0] exp_t  [R];
  int            exp_ix [R];
  int            exp_n;

  task automatic build_model(input logic [R-1:0] mask, input logic [TW-1:0] dl [R]);
    logic [TW-1:0] tt;
    int            ti;
    exp_n = 0;
    for (int i = 0; i < int'(R); i++) begin
      if (mask[i]) begin
        exp_t[exp_n]  = dl[i];
        exp_ix[exp_n] = i;
        exp_n++;
      end
    end
    for (int a = 0; a < exp_n; a++) begin
      for (int b = 0; b + 1 < exp_n - a; b++) begin
        if (exp_t[b] > exp_t[b+1] || (exp_t[b] == exp_t[b+1] && exp_ix[b] > exp_ix[b+1])) begin
          tt = exp_t[b];  exp_t[b]  = exp_t[b+1];  exp_t[b+1]  = tt;
          ti = exp_ix[b]; exp_ix[b] = exp_ix[b+1]; exp_ix[b+1] = ti;
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [TW-1:0] prev;
    logic [TW-1:0] lo;
    check({tag, "_nwr"}, 64'(wq.size()), 64'(exp_n + 1));
    check({tag, "_ndone"}, 64'(dq_idx.size()), 64'(exp_n));
    prev = '0;
    for (int i = 0; i < exp_n; i++) begin
      check($sformatf("%s_wr%0d", tag, i), wq_at(i), exp_t[i]);
      check($sformatf("%s_done%0d", tag, i), 64'(dq_at(i)), 64'(exp_ix[i]));
      check($sformatf("%s_late%0d", tag, i), 64'(dnow_at(i) >= exp_t[i]), 64'd1);
      lo = (exp_t[i] > prev) ? exp_t[i] : prev;
      check($sformatf("%s_prompt%0d", tag, i), 64'(dnow_at(i) <= lo + 64'(R + 8)), 64'd1);
      prev = dnow_at(i);
    end
    check({tag, "_park"}, wq_at(exp_n), PARK);
  endtask

  logic [TW-1:0] dl [R];
  logic [R-1:0]  mask;
  logic [TW-1:0] base;
  int            acc_cyc;

  initial begin
    bus.req_valid = '0;
    bus.req_time  = '0;
    bus.cancel    = '0;

    // Reset values
    tick(2);
    check("rst_armed", 64'(bus.armed), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    check("rst_we", 64'(bus.timecmp_we), 64'd0);
    check("rst_wdata", bus.timecmp_wdata, 64'd0);
    HRESET = 1'b0;
    tick(1);
    check("idle_ready", 64'(bus.req_ready), 64'hF);

    // Single arm
    set_time(0);
    clear_log();
    bus.req_valid[0] = 1'b1;
    bus.req_time[0*TW +: TW] = 64'd60;
    tick(1);
    bus.req_valid = '0;
    check("single_armed", 64'(bus.armed), 64'h1);
    wait_idle("single_idle", 300);
    check("single_nwr", 64'(wq.size()), 64'd2);
    check("single_wr0", wq_at(0), 64'd60);
    check("single_park", wq_at(1), PARK);
    check("single_ndone", 64'(dq_idx.size()), 64'd1);
    check("single_idx", 64'(dq_at(0)), 64'd0);
    check("single_when", 64'(dnow_at(0) >= 64'd60 && dnow_at(0) <= 64'd62), 64'd1);
    check("single_armed_end", 64'(bus.armed), 64'd0);

    // Ordering with a tie
    set_time(0);
    clear_log();
    bus.req_valid = 4'hF;
    bus.req_time[0*TW +: TW] = 64'd400;
    bus.req_time[1*TW +: TW] = 64'd100;
    bus.req_time[2*TW +: TW] = 64'd300;
    bus.req_time[3*TW +: TW] = 64'd100;
    tick(1);
    bus.req_valid = '0;
    check("order_armed", 64'(bus.armed), 64'hF);
    wait_idle("order_idle", 1000);
    check("order_nwr", 64'(wq.size()), 64'd5);
    check("order_wr0", wq_at(0), 64'd100);
    check("order_wr1", wq_at(1), 64'd100);
    check("order_wr2", wq_at(2), 64'd300);
    check("order_wr3", wq_at(3), 64'd400);
    check("order_wr4", wq_at(4), PARK);
    check("order_d0", 64'(dq_at(0)), 64'd1);
    check("order_d1", 64'(dq_at(1)), 64'd3);
    check("order_d2", 64'(dq_at(2)), 64'd2);
    check("order_d3", 64'(dq_at(3)), 64'd0);

    // Preemption by an earlier deadline
    set_time(0);
    clear_log();
    bus.req_valid[2] = 1'b1;
    bus.req_time[2*TW +: TW] = 64'd1000;
    tick(1);
    bus.req_valid = '0;
    wait_time("pre_t50", 64'd50, 100);
    check("pre_ready0", 64'(bus.req_ready[0]), 64'd1);
    bus.req_valid[0] = 1'b1;
    bus.req_time[0*TW +: TW] = 64'd200;
    tick(1);
    bus.req_valid = '0;
    wait_idle("pre_idle", 2000);
    check("pre_nwr", 64'(wq.size()), 64'd4);
    check("pre_wr0", wq_at(0), 64'd1000);
    check("pre_wr1", wq_at(1), 64'd200);
    check("pre_wr2", wq_at(2), 64'd1000);
    check("pre_wr3", wq_at(3), PARK);
    check("pre_d0", 64'(dq_at(0)), 64'd0);
    check("pre_d1", 64'(dq_at(1)), 64'd2);
    check("pre_when0", 64'(dnow_at(0) >= 64'd200 && dnow_at(0) <= 64'd203), 64'd1);
    check("pre_when1", 64'(dnow_at(1) >= 64'd1000 && dnow_at(1) <= 64'd1003), 64'd1);

    // Cancel of the active slot in the cycle the interrupt rises
    set_time(0);
    clear_log();
    bus.req_valid[1] = 1'b1;
    bus.req_time[1*TW +: TW] = 64'd300;
    tick(1);
    bus.req_valid = '0;
    wait_time("cxl_t300", 64'd300, 400);
    check("cxl_tint", 64'(bus.tint), 64'd1);
    bus.cancel[1] = 1'b1;
    tick(1);
    bus.cancel = '0;
    check("cxl_armed", 64'(bus.armed), 64'd0);
    wait_idle("cxl_idle", 100);
    check("cxl_ndone", 64'(dq_idx.size()), 64'd0);
    check("cxl_nwr", 64'(wq.size()), 64'd2);
    check("cxl_wr0", wq_at(0), 64'd300);
    check("cxl_park", wq_at(1), PARK);
    check("cxl_ready", 64'(bus.req_ready), 64'hF);

    // Deadline already in the past
    set_time(100);
    clear_log();
    bus.req_valid[3] = 1'b1;
    bus.req_time[3*TW +: TW] = 64'd5;
    tick(1);
    acc_cyc = cyc;
    bus.req_valid = '0;
    wait_idle("past_idle", 100);
    check("past_wr0", wq_at(0), 64'd5);
    check("past_park", wq_at(1), PARK);
    check("past_ndone", 64'(dq_idx.size()), 64'd1);
    check("past_idx", 64'(dq_at(0)), 64'd3);
    check("past_lat", 64'((dq_cyc.size() > 0) ? dq_cyc[0] - acc_cyc : -1), 64'(R + 3));
    check("past_ready", 64'(bus.req_ready), 64'hF);

    // Randomized arm sets against the sorted-deadline reference
    for (int it = 0; it < 8; it++) begin
      clear_log();
      base = now;
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < int'(R); i++) begin
        dl[i] = base + 64'(10 + 16 * $urandom_range(0, 6));
        bus.req_time[i*TW +: TW] = dl[i];
      end
      build_model(mask, dl);
      bus.req_valid = mask;
      tick(1);
      bus.req_valid = '0;
      check($sformatf("rnd%0d_armed", it), 64'(bus.armed), 64'(mask));
      wait_idle($sformatf("rnd%0d_idle", it), 1000);
      check_model($sformatf("rnd%0d", it));
    end

    // Reset while waiting; a stale interrupt afterwards must not produce anything
    set_time(0);
    clear_log();
    bus.req_valid[1] = 1'b1;
    bus.req_time[1*TW +: TW] = 64'd500;
    tick(1);
    bus.req_valid = '0;
    tick(10);
    check("rw_armed_pre", 64'(bus.armed), 64'h2);
    HRESET = 1'b1;
    #1;
    check("rw_armed", 64'(bus.armed), 64'd0);
    check("rw_done", 64'(bus.done), 64'd0);
    check("rw_ready", 64'(bus.req_ready), 64'd0);
    check("rw_we", 64'(bus.timecmp_we), 64'd0);
    check("rw_wdata", bus.timecmp_wdata, 64'd0);
    tick(1);
    HRESET = 1'b0;
    clear_log();
    wait_time("rw_t520", 64'd520, 600);
    check("rw_nwr", 64'(wq.size()), 64'd0);
    check("rw_ndone", 64'(dq_idx.size()), 64'd0);
    check("rw_armed_end", 64'(bus.armed), 64'd0);

    check("invariants", 64'(inv_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
